// File: rtl/wishbone_gpio_bank.sv
// Wishbone GPIO bank: per-pin direction/output, atomic set/clear, synchronised inputs
// and per-pin rising/falling edge capture folded into one registered level IRQ.
module wishbone_gpio_bank #(
    parameter int NB_GPIO     = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int WB_DATA     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  gls_clk,
    input  logic                  gls_reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [WB_DATA-1:0]    wbs_writedata,
    output logic [WB_DATA-1:0]    wbs_readdata,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    input  logic                  wbs_write,
    output logic                  wbs_ack,
    inout  wire  [NB_GPIO-1:0]    gpio,
    output logic                  irq
);

    typedef enum logic [2:0] {
        A_DIR    = 3'd0,
        A_OUT    = 3'd1,
        A_IN     = 3'd2,
        A_SET    = 3'd3,
        A_CLR    = 3'd4,
        A_RISE   = 3'd5,
        A_FALL   = 3'd6,
        A_STATUS = 3'd7
    } reg_addr_t;

    // Registers are kept 16 bits wide; bits at or above NB_GPIO are forced to zero
    // through this mask and optimise away in synthesis.
    localparam logic [15:0] PIN_MASK = 16'((32'd1 << NB_GPIO) - 32'd1);

    logic [15:0] dir_q, out_q, rise_en_q, fall_en_q, status_q, hist_q;
    logic [15:0] dir_d, out_d, rise_en_d, fall_en_d, status_d;
    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] pad_in, in_val, edge_set, wd, w1c, rd_data;
    logic        req, wr;
    reg_addr_t   addr;
    logic        unused_addr;

    assign unused_addr = ^wbs_address[ADDR_WIDTH-1:3];
    assign addr        = reg_addr_t'(wbs_address[2:0]);
    assign req         = wbs_cycle & wbs_strobe & ~wbs_ack;
    assign wr          = req & wbs_write;
    assign wd          = 16'(wbs_writedata) & PIN_MASK;

    for (genvar i = 0; i < NB_GPIO; i++) begin : g_pad
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        pad_in              = '0;
        pad_in[NB_GPIO-1:0] = gpio;
    end

    assign in_val   = sync_q[SYNC_STAGES-1] & PIN_MASK;
    assign edge_set = (in_val & ~hist_q & rise_en_q) | (~in_val & hist_q & fall_en_q);

    // NOTE: every output of this block gets its hold value first, so an address
    // that does not write a register can never infer a latch.
    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr) begin
            case (addr)
                A_DIR:    dir_d     = wd;
                A_OUT:    out_d     = wd;
                A_SET:    out_d     = out_q | wd;
                A_CLR:    out_d     = out_q & ~wd;
                A_RISE:   rise_en_d = wd;
                A_FALL:   fall_en_d = wd;
                A_STATUS: w1c       = wd;
                default:  ;
            endcase
        end
        // Clear first, then OR in new events, so a coincident edge wins over W1C.
        status_d = (status_q & ~w1c) | edge_set;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            A_DIR:    rd_data = dir_q;
            A_OUT:    rd_data = out_q;
            A_IN:     rd_data = in_val;
            A_RISE:   rd_data = rise_en_q;
            A_FALL:   rd_data = fall_en_q;
            A_STATUS: rd_data = status_q;
            default:  rd_data = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, which the synchroniser shift below depends on.
    always_ff @(posedge gls_clk) begin
        if (gls_reset) begin
            wbs_ack      <= 1'b0;
            wbs_readdata <= '0;
            dir_q        <= '0;
            out_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            status_q     <= '0;
            hist_q       <= '0;
            irq          <= 1'b0;
            // NOTE: the synchroniser array is a handful of flops, not a RAM,
            // so it is reset like any other register.
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            wbs_ack      <= req;
            wbs_readdata <= WB_DATA'((req && !wbs_write) ? rd_data : 16'h0000);
            dir_q        <= dir_d;
            out_q        <= out_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            status_q     <= status_d;
            sync_q[0]    <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            hist_q       <= in_val;
            irq          <= |(status_q & (rise_en_q | fall_en_q));
        end
    end

endmodule

// File: tb/tb_wishbone_gpio_bank.sv
// Scoreboard bench for wishbone_gpio_bank: a 16-pin instance (a) and a 4-pin instance (b)
// share clock and reset; stimulus queues expectations, a negedge monitor compares them.
module tb_wishbone_gpio_bank;

    localparam int SYNC = 2;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        string       name;
    } rd_t;

    typedef enum int {K_IRQ, K_PAD, K_ACK, K_TIMEOUT, K_DRAIN} kind_t;

    typedef struct {
        kind_t       kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] adr_a = '0, wd_a = '0, rd_a;
    logic        cyc_a = 1'b0, stb_a = 1'b0, we_a = 1'b0, ack_a, irq_a;
    wire  [15:0] gpio_a;
    logic [15:0] tb_en = 16'hFFFF, tb_val = 16'h0000;

    logic [15:0] adr_b = '0, wd_b = '0, rd_b;
    logic        cyc_b = 1'b0, stb_b = 1'b0, we_b = 1'b0, ack_b, irq_b;
    wire  [3:0]  gpio_b;

    rd_t  q_a[$];
    rd_t  q_b[$];
    chk_t chk_q[$];

    int   num_checks = 0;
    int   num_errors = 0;
    logic ack_prev_a = 1'b0, ack_prev_b = 1'b0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 16; i++) begin : g_drv
        assign gpio_a[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    wishbone_gpio_bank #(.NB_GPIO(16), .ADDR_WIDTH(16), .WB_DATA(16), .SYNC_STAGES(SYNC)) dut_a (
        .gls_clk(clk), .gls_reset(rst), .wbs_address(adr_a), .wbs_writedata(wd_a),
        .wbs_readdata(rd_a), .wbs_strobe(stb_a), .wbs_cycle(cyc_a), .wbs_write(we_a),
        .wbs_ack(ack_a), .gpio(gpio_a), .irq(irq_a)
    );

    wishbone_gpio_bank #(.NB_GPIO(4), .ADDR_WIDTH(16), .WB_DATA(16), .SYNC_STAGES(SYNC)) dut_b (
        .gls_clk(clk), .gls_reset(rst), .wbs_address(adr_b), .wbs_writedata(wd_b),
        .wbs_readdata(rd_b), .wbs_strobe(stb_b), .wbs_cycle(cyc_b), .wbs_write(we_b),
        .wbs_ack(ack_b), .gpio(gpio_b), .irq(irq_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: the only process that compares and steps the counters.
    always @(negedge clk) begin : monitor
        rd_t  e;
        chk_t c;
        if (ack_a) begin
            check("ack_a_one_cycle", {15'b0, ack_prev_a}, 16'h0000);
            check("ack_a_expected", {15'b0, q_a.size() != 0}, 16'h0001);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                if (e.is_read) check(e.name, rd_a, e.data);
            end
        end else begin
            check("rd_a_zero_when_idle", rd_a, 16'h0000);
        end
        if (ack_b) begin
            check("ack_b_one_cycle", {15'b0, ack_prev_b}, 16'h0000);
            check("ack_b_expected", {15'b0, q_b.size() != 0}, 16'h0001);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                if (e.is_read) check(e.name, rd_b, e.data);
            end
        end
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            case (c.kind)
                K_IRQ:     check(c.name, {15'b0, irq_a}, c.exp);
                K_PAD:     check(c.name, {8'b0, gpio_a[7:0]}, c.exp);
                K_ACK:     check(c.name, {15'b0, ack_a}, c.exp);
                K_TIMEOUT: check(c.name, c.exp, 16'h0001);
                K_DRAIN:   check(c.name, 16'(q_a.size() + q_b.size()), 16'h0000);
                default:   ;
            endcase
        end
        ack_prev_a <= ack_a;
        ack_prev_b <= ack_b;
    end

    task automatic expect_side(input kind_t kind, input logic [15:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    // One Wishbone transfer; called just after a rising edge, returns just after one.
    task automatic wb(input int d, input bit we, input logic [2:0] a,
                      input logic [15:0] wdat, input logic [15:0] exp, input string name);
        rd_t  e;
        logic got;
        e.is_read = !we;
        e.data    = exp;
        e.name    = name;
        got       = 1'b0;
        if (d == 0) begin
            q_a.push_back(e);
            cyc_a = 1'b1; stb_a = 1'b1; we_a = we; adr_a = {13'h0, a}; wd_a = wdat;
        end else begin
            q_b.push_back(e);
            cyc_b = 1'b1; stb_b = 1'b1; we_b = we; adr_b = {13'h0, a}; wd_b = wdat;
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            got = (d == 0) ? ack_a : ack_b;
            if (got) break;
        end
        if (d == 0) begin
            cyc_a = 1'b0; stb_a = 1'b0; we_a = 1'b0;
        end else begin
            cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0;
        end
        if (!got) begin
            expect_side(K_TIMEOUT, {15'b0, got}, {name, "_ack_timeout"});
            if (d == 0) void'(q_a.pop_back());
            else        void'(q_b.pop_back());
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // 1. reset state and all addresses read back zero
        cycles(3);
        rst = 1'b0;
        cycles(SYNC + 2);
        expect_side(K_IRQ, 16'h0000, "irq_after_reset");
        for (int i = 0; i < 8; i++) wb(0, 1'b0, 3'(i), 16'h0000, 16'h0000, $sformatf("reset_read_%0d", i));

        // 2. low byte output, high byte input driven by the bench
        tb_en  = 16'hFF00;
        tb_val = 16'h3C00;
        wb(0, 1'b1, 3'd0, 16'h00FF, 16'h0000, "wr_dir");
        wb(0, 1'b1, 3'd1, 16'h00A5, 16'h0000, "wr_out");
        expect_side(K_PAD, 16'h00A5, "pad_low_byte");
        wb(0, 1'b0, 3'd0, 16'h0000, 16'h00FF, "rd_dir");
        cycles(SYNC + 2);
        wb(0, 1'b0, 3'd2, 16'h0000, 16'h3CA5, "rd_in_mixed");
        wb(0, 1'b1, 3'd2, 16'hFFFF, 16'h0000, "wr_in_ignored");
        wb(0, 1'b0, 3'd1, 16'h0000, 16'h00A5, "rd_out_after_ro_write");

        // 3. atomic set / clear
        wb(0, 1'b1, 3'd3, 16'h0102, 16'h0000, "wr_set");
        wb(0, 1'b1, 3'd4, 16'h0005, 16'h0000, "wr_clr");
        wb(0, 1'b0, 3'd1, 16'h0000, 16'h01A2, "rd_out_set_clr");
        expect_side(K_PAD, 16'h00A2, "pad_after_set_clr");
        wb(0, 1'b0, 3'd3, 16'h0000, 16'h0000, "rd_set_zero");
        wb(0, 1'b0, 3'd4, 16'h0000, 16'h0000, "rd_clr_zero");

        // 4. rising edge on pin 0 -> STATUS and irq after SYNC+2 cycles, then W1C
        wb(0, 1'b1, 3'd0, 16'h0000, 16'h0000, "wr_dir_inputs");
        tb_en  = 16'hFFFF;
        tb_val = 16'h00A2;
        cycles(SYNC + 2);
        wb(0, 1'b1, 3'd5, 16'h0001, 16'h0000, "wr_rise_en");
        wb(0, 1'b0, 3'd7, 16'h0000, 16'h0000, "rd_status_quiet");
        tb_val[0] = 1'b1;
        cycles(SYNC + 1);
        expect_side(K_IRQ, 16'h0000, "irq_not_yet");
        cycles(1);
        expect_side(K_IRQ, 16'h0001, "irq_rise");
        wb(0, 1'b0, 3'd7, 16'h0000, 16'h0001, "rd_status_rise");
        wb(0, 1'b1, 3'd7, 16'h0001, 16'h0000, "w1c_bit0");
        cycles(1);
        expect_side(K_IRQ, 16'h0000, "irq_after_w1c");
        wb(0, 1'b0, 3'd7, 16'h0000, 16'h0000, "rd_status_cleared");

        // 5. falling edge on pin 1 coincides with W1C of bit 1 -> set wins
        wb(0, 1'b1, 3'd6, 16'h0002, 16'h0000, "wr_fall_en");
        tb_val[1] = 1'b0;
        cycles(SYNC);
        wb(0, 1'b1, 3'd7, 16'h0002, 16'h0000, "w1c_vs_fall");
        wb(0, 1'b0, 3'd7, 16'h0000, 16'h0002, "rd_status_set_wins");
        expect_side(K_IRQ, 16'h0001, "irq_fall");
        wb(0, 1'b1, 3'd6, 16'h0000, 16'h0000, "wr_fall_dis");
        cycles(1);
        expect_side(K_IRQ, 16'h0000, "irq_masked");
        wb(0, 1'b0, 3'd7, 16'h0000, 16'h0002, "rd_status_kept");

        // 6. reset while a write to OUT is held on the bus
        rst   = 1'b1;
        cyc_a = 1'b1; stb_a = 1'b1; we_a = 1'b1; adr_a = 16'h0001; wd_a = 16'h1234;
        cycles(1);
        expect_side(K_ACK, 16'h0000, "no_ack_in_reset_0");
        cycles(1);
        expect_side(K_ACK, 16'h0000, "no_ack_in_reset_1");
        cyc_a = 1'b0; stb_a = 1'b0; we_a = 1'b0;
        cycles(1);
        rst = 1'b0;
        cycles(1);
        expect_side(K_IRQ, 16'h0000, "irq_after_mid_reset");
        wb(0, 1'b0, 3'd1, 16'h0000, 16'h0000, "rd_out_after_mid_reset");
        wb(0, 1'b0, 3'd7, 16'h0000, 16'h0000, "rd_status_after_mid_reset");
        wb(0, 1'b0, 3'd5, 16'h0000, 16'h0000, "rd_rise_after_mid_reset");

        // 4-pin instance: upper data bits read 0 and are not stored
        wb(1, 1'b1, 3'd0, 16'hFFFF, 16'h0000, "b_wr_dir");
        wb(1, 1'b0, 3'd0, 16'h0000, 16'h000F, "b_rd_dir");
        wb(1, 1'b1, 3'd1, 16'hFFF5, 16'h0000, "b_wr_out");
        wb(1, 1'b0, 3'd1, 16'h0000, 16'h0005, "b_rd_out");
        cycles(SYNC + 2);
        wb(1, 1'b0, 3'd2, 16'h0000, 16'h0005, "b_rd_in");
        wb(1, 1'b1, 3'd5, 16'hABCD, 16'h0000, "b_wr_rise");
        wb(1, 1'b0, 3'd5, 16'h0000, 16'h000D, "b_rd_rise");

        cycles(3);
        expect_side(K_DRAIN, 16'h0000, "scoreboard_drained");
        cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
